// File: rtl/memory_access_stage.sv
// MEM pipeline stage: turns load/store controls into a req/gnt/rvalid data-memory
// transaction, aligns store lanes, extends load data and stalls while busy.
module memory_access_stage #(
    parameter int unsigned GNT_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        valid_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  write_reg_i,
    input  logic [1:0]  mem_to_reg_i,
    input  logic        reg_write_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] data_read_o,
    output logic [31:0] alu_result_o,
    output logic [4:0]  write_reg_o,
    output logic [1:0]  mem_to_reg_o,
    output logic        reg_write_o,
    output logic        misaligned_o,
    output logic        bus_error_o
);
    localparam int unsigned CntW = $clog2(GNT_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRdata} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, wdata_q, alu_q;
    logic [3:0]      be_q;
    logic            we_q, rw_q;
    logic [2:0]      f3_q;
    logic [4:0]      wreg_q;
    logic [1:0]      m2r_q;
    logic            capture;
    logic            timeout;

    logic            is_mem, is_b, is_h, is_w, misal;
    logic [1:0]      off;
    logic [3:0]      be_in;
    logic [31:0]     wdata_in;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     load_data;

    assign off     = alu_result_i[1:0];
    assign is_mem  = mem_read_i | mem_write_i;
    assign is_b    = (funct3_i[1:0] == 2'b00);
    assign is_h    = (funct3_i[1:0] == 2'b01);
    // Undefined size encodings fall through to word accesses.
    assign is_w    = !is_b && !is_h;
    assign misal   = (is_h && off[0]) || (is_w && (off != 2'b00));
    assign timeout = (cnt_q == CntW'(GNT_TIMEOUT));

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = store_data_i;
        if (is_b) begin
            be_in    = 4'b0001 << off;
            wdata_in = {4{store_data_i[7:0]}};
        end else if (is_h) begin
            be_in    = off[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{store_data_i[15:0]}};
        end
    end

    always_comb begin
        lane_b = 8'(dmem_rdata_i >> {alu_q[1:0], 3'b000});
        lane_h = alu_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (f3_q[1:0])
            2'b00:   load_data = f3_q[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_data = f3_q[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CntW'(1);
        capture      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = '0;
        dmem_wdata_o = '0;
        stall_o      = 1'b0;
        valid_o      = 1'b0;
        data_read_o  = '0;
        alu_result_o = '0;
        write_reg_o  = '0;
        mem_to_reg_o = '0;
        reg_write_o  = 1'b0;
        misaligned_o = 1'b0;
        bus_error_o  = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Reset gating keeps every output at zero while reset is held.
                if (valid_i && reset_ni) begin
                    alu_result_o = alu_result_i;
                    write_reg_o  = write_reg_i;
                    mem_to_reg_o = mem_to_reg_i;
                    if (!is_mem) begin
                        valid_o     = 1'b1;
                        reg_write_o = reg_write_i;
                    end else if (misal) begin
                        valid_o      = 1'b1;
                        misaligned_o = 1'b1;
                    end else begin
                        capture      = 1'b1;
                        dmem_req_o   = 1'b1;
                        dmem_we_o    = mem_write_i;
                        dmem_addr_o  = {alu_result_i[31:2], 2'b00};
                        dmem_be_o    = be_in;
                        dmem_wdata_o = wdata_in;
                        if (dmem_gnt_i && mem_write_i) begin
                            valid_o     = 1'b1;
                            reg_write_o = reg_write_i;
                        end else begin
                            stall_o = 1'b1;
                            state_d = dmem_gnt_i ? StWaitRdata : StWaitGnt;
                        end
                    end
                end
            end
            StWaitGnt: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_addr_o  = addr_q;
                dmem_be_o    = be_q;
                dmem_wdata_o = wdata_q;
                if (dmem_gnt_i && !we_q) begin
                    stall_o = 1'b1;
                    cnt_d   = '0;
                    state_d = StWaitRdata;
                end else if (dmem_gnt_i || timeout) begin
                    valid_o      = 1'b1;
                    bus_error_o  = !dmem_gnt_i;
                    reg_write_o  = dmem_gnt_i && rw_q;
                    alu_result_o = alu_q;
                    write_reg_o  = wreg_q;
                    mem_to_reg_o = m2r_q;
                    state_d      = StIdle;
                end else begin
                    stall_o = 1'b1;
                end
            end
            StWaitRdata: begin
                if (dmem_rvalid_i || timeout) begin
                    valid_o      = 1'b1;
                    bus_error_o  = !dmem_rvalid_i;
                    reg_write_o  = dmem_rvalid_i && rw_q;
                    data_read_o  = dmem_rvalid_i ? load_data : '0;
                    alu_result_o = alu_q;
                    write_reg_o  = wreg_q;
                    mem_to_reg_o = m2r_q;
                    state_d      = StIdle;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            alu_q   <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            rw_q    <= 1'b0;
            f3_q    <= '0;
            wreg_q  <= '0;
            m2r_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= {alu_result_i[31:2], 2'b00};
                wdata_q <= wdata_in;
                alu_q   <= alu_result_i;
                be_q    <= be_in;
                we_q    <= mem_write_i;
                rw_q    <= reg_write_i;
                f3_q    <= funct3_i;
                wreg_q  <= write_reg_i;
                m2r_q   <= mem_to_reg_i;
            end
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: single-cycle vector table, hand-written multi-cycle
// sequences and randomized transactions against an arithmetic reference model.
module tb_memory_access_stage;
    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] store_data_i = '0;
    logic [4:0]  write_reg_i = '0;
    logic [1:0]  mem_to_reg_i = '0;
    logic        reg_write_i = 1'b0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        stall_o, valid_o, reg_write_o, misaligned_o, bus_error_o;
    logic [31:0] data_read_o, alu_result_o;
    logic [4:0]  write_reg_o;
    logic [1:0]  mem_to_reg_o;

    int n_cmp = 0;
    int n_err = 0;

    memory_access_stage #(.GNT_TIMEOUT(16)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .write_reg_i(write_reg_i), .mem_to_reg_i(mem_to_reg_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .valid_o(valid_o),
        .data_read_o(data_read_o), .alu_result_o(alu_result_o),
        .write_reg_o(write_reg_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_write_o(reg_write_o), .misaligned_o(misaligned_o), .bus_error_o(bus_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] wreg,
                         input logic [1:0] m2r, input logic rw);
        valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
        alu_result_i = addr; store_data_i = sd; write_reg_i = wreg;
        mem_to_reg_i = m2r; reg_write_i = rw;
    endtask

    task automatic idle_in();
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; reg_write_i = 1'b0;
    endtask

    // Reference model: access size in bytes from funct3 (unknown encodings are words).
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = acc_size(f3);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        int     sz = acc_size(f3);
        longint v;
        v = longint'(w >> (8 * (a % 4))) & ((longint'(1) << (8 * sz)) - 1);
        if (sz < 4 && !f3[2] && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    typedef struct {
        logic rd, wr, vin, gnt, rw;
        logic [2:0] f3;
        logic [31:0] addr, sd;
        logic [4:0] wreg;
        logic e_req, e_we, e_valid, e_stall, e_mis, e_rw;
        logic [31:0] e_addr, e_wdata;
        logic [3:0] e_be;
        string name;
    } vec_t;

    vec_t vecs[9];

    task automatic run_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input int dg, input int dr, input logic early_rv,
                            input logic [31:0] rdata, input logic [31:0] exp);
        int done = 0;
        drive(1'b1, 1'b0, f3, addr, 32'h0, 5'd9, 2'd1, 1'b1);
        dmem_rdata_i = rdata;
        for (int c = 0; c < 30 && done == 0; c++) begin
            dmem_gnt_i    = (c == dg);
            dmem_rvalid_i = (c == dg + dr) || (early_rv && c == dg);
            #2;
            if (c == dg + dr) begin
                chk({nm, " valid"}, valid_o, 1'b1);
                chk({nm, " stall_done"}, stall_o, 1'b0);
                chk({nm, " data"}, data_read_o, exp);
                chk({nm, " reg_write"}, reg_write_o, 1'b1);
                done = 1;
            end else if (stall_o !== 1'b1 || valid_o !== 1'b0) begin
                chk({nm, " stall_busy"}, {stall_o, valid_o}, 2'b10);
            end
            next_cycle();
            if (done != 0) idle_in();
        end
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        if (done == 0) chk({nm, " completion_bound"}, 0, 1);
        next_cycle();
    endtask

    initial begin
        vecs[0] = '{rd:0, wr:0, vin:1, gnt:0, rw:1, f3:3'd0, addr:32'h1234, sd:0, wreg:5,
                    e_req:0, e_we:0, e_valid:1, e_stall:0, e_mis:0, e_rw:1, e_addr:0,
                    e_wdata:0, e_be:4'b0000, name:"add_pass"};
        vecs[1] = '{rd:0, wr:1, vin:1, gnt:1, rw:0, f3:3'd0, addr:32'h103, sd:32'h1234_56AB,
                    wreg:0, e_req:1, e_we:1, e_valid:1, e_stall:0, e_mis:0, e_rw:0,
                    e_addr:32'h100, e_wdata:32'hABAB_ABAB, e_be:4'b1000, name:"sb_0wait"};
        vecs[2] = '{rd:0, wr:1, vin:1, gnt:1, rw:0, f3:3'd1, addr:32'h102, sd:32'h7777_BEEF,
                    wreg:0, e_req:1, e_we:1, e_valid:1, e_stall:0, e_mis:0, e_rw:0,
                    e_addr:32'h100, e_wdata:32'hBEEF_BEEF, e_be:4'b1100, name:"sh_hi"};
        vecs[3] = '{rd:0, wr:1, vin:1, gnt:1, rw:0, f3:3'd2, addr:32'h200, sd:32'hDEAD_BEEF,
                    wreg:0, e_req:1, e_we:1, e_valid:1, e_stall:0, e_mis:0, e_rw:0,
                    e_addr:32'h200, e_wdata:32'hDEAD_BEEF, e_be:4'b1111, name:"sw"};
        vecs[4] = '{rd:1, wr:0, vin:1, gnt:0, rw:1, f3:3'd2, addr:32'h102, sd:0, wreg:7,
                    e_req:0, e_we:0, e_valid:1, e_stall:0, e_mis:1, e_rw:0, e_addr:0,
                    e_wdata:0, e_be:4'b0000, name:"lw_misal"};
        vecs[5] = '{rd:1, wr:0, vin:1, gnt:0, rw:1, f3:3'd1, addr:32'h101, sd:0, wreg:7,
                    e_req:0, e_we:0, e_valid:1, e_stall:0, e_mis:1, e_rw:0, e_addr:0,
                    e_wdata:0, e_be:4'b0000, name:"lh_misal"};
        vecs[6] = '{rd:0, wr:1, vin:1, gnt:0, rw:0, f3:3'd6, addr:32'h206, sd:32'h1, wreg:0,
                    e_req:0, e_we:0, e_valid:1, e_stall:0, e_mis:1, e_rw:0, e_addr:0,
                    e_wdata:0, e_be:4'b0000, name:"undef_f3_misal"};
        vecs[7] = '{rd:1, wr:1, vin:1, gnt:1, rw:0, f3:3'd0, addr:32'h101, sd:32'h5A, wreg:0,
                    e_req:1, e_we:1, e_valid:1, e_stall:0, e_mis:0, e_rw:0, e_addr:32'h100,
                    e_wdata:32'h5A5A_5A5A, e_be:4'b0010, name:"rd_wr_is_store"};
        vecs[8] = '{rd:1, wr:0, vin:0, gnt:1, rw:1, f3:3'd2, addr:32'h300, sd:0, wreg:3,
                    e_req:0, e_we:0, e_valid:0, e_stall:0, e_mis:0, e_rw:0, e_addr:0,
                    e_wdata:0, e_be:4'b0000, name:"valid_low"};

        // Reset state
        #2;
        chk("rst valid", valid_o, 1'b0);
        chk("rst stall", stall_o, 1'b0);
        chk("rst req", dmem_req_o, 1'b0);
        chk("rst faults", {misaligned_o, bus_error_o, reg_write_o}, 3'b000);
        next_cycle();
        reset_ni = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sd,
                  vecs[i].wreg, 2'd2, vecs[i].rw);
            valid_i = vecs[i].vin;
            dmem_gnt_i = vecs[i].gnt;
            #2;
            chk({vecs[i].name, " req"}, dmem_req_o, vecs[i].e_req);
            chk({vecs[i].name, " we"}, dmem_we_o, vecs[i].e_we);
            chk({vecs[i].name, " addr"}, dmem_addr_o, vecs[i].e_addr);
            chk({vecs[i].name, " be"}, dmem_be_o, vecs[i].e_be);
            chk({vecs[i].name, " wdata"}, dmem_wdata_o, vecs[i].e_wdata);
            chk({vecs[i].name, " valid"}, valid_o, vecs[i].e_valid);
            chk({vecs[i].name, " stall"}, stall_o, vecs[i].e_stall);
            chk({vecs[i].name, " misaligned"}, misaligned_o, vecs[i].e_mis);
            chk({vecs[i].name, " reg_write"}, reg_write_o, vecs[i].e_rw);
            chk({vecs[i].name, " alu_result"}, alu_result_o,
                vecs[i].e_valid ? vecs[i].addr : 32'h0);
            chk({vecs[i].name, " write_reg"}, write_reg_o,
                vecs[i].e_valid ? vecs[i].wreg : 5'd0);
            next_cycle();
            idle_in();
            dmem_gnt_i = 1'b0;
            #2;
            chk({vecs[i].name, " after"}, {valid_o, stall_o, misaligned_o}, 3'b000);
            next_cycle();
        end

        run_load("lb_waited", 3'b000, 32'h101, 2, 3, 1'b0, 32'h0000_8000, 32'hFFFF_FF80);
        run_load("lbu_waited", 3'b100, 32'h101, 2, 3, 1'b0, 32'h0000_8000, 32'h0000_0080);
        run_load("lh_rv_with_gnt", 3'b001, 32'h402, 0, 1, 1'b1, 32'h8001_1234, 32'hFFFF_8001);

        // Timeout: grant never arrives.
        begin
            int seen = -1;
            drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd4, 2'd1, 1'b1);
            #2;
            chk("to first stall", stall_o, 1'b1);
            next_cycle();
            for (int k = 0; k < 40 && seen < 0; k++) begin
                #2;
                if (bus_error_o === 1'b1) begin
                    seen = k;
                    chk("to cycle", k, 16);
                    chk("to valid", valid_o, 1'b1);
                    chk("to reg_write", reg_write_o, 1'b0);
                    chk("to stall", stall_o, 1'b0);
                end else if (stall_o !== 1'b1) begin
                    chk("to stall_wait", stall_o, 1'b1);
                end
                next_cycle();
            end
            idle_in();
            if (seen < 0) chk("to bound", 0, 1);
            #2;
            chk("to after", {stall_o, bus_error_o, valid_o}, 3'b000);
            next_cycle();
        end

        // Reset while waiting for read data, then a stray rvalid.
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd6, 2'd1, 1'b1);
        dmem_gnt_i = 1'b1;
        next_cycle();
        dmem_gnt_i = 1'b0;
        #2;
        chk("mr wait stall", stall_o, 1'b1);
        reset_ni = 1'b0;
        #1;
        chk("mr rst outs", {stall_o, valid_o, dmem_req_o, reg_write_o, misaligned_o,
                            bus_error_o}, 6'b0);
        chk("mr rst data", data_read_o | alu_result_o, 32'h0);
        next_cycle();
        next_cycle();
        reset_ni = 1'b1;
        idle_in();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("mr stray rvalid", {valid_o, stall_o}, 2'b00);
            next_cycle();
        end
        dmem_rvalid_i = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd1, 2'd0, 1'b1);
        #2;
        chk("mr idle after", valid_o, 1'b1);
        next_cycle();
        idle_in();
        next_cycle();

        // Randomized transactions against the reference model.
        for (int t = 0; t < 80; t++) begin
            int          kind = $urandom_range(0, 4);
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            logic [31:0] sd = $urandom;
            logic [31:0] rdata = $urandom;
            logic [4:0]  wreg = 5'($urandom_range(0, 31));
            logic        rw = 1'($urandom_range(0, 1));
            int          dg = $urandom_range(0, 3);
            int          dr = $urandom_range(1, 3);
            logic        ld = (kind <= 1);
            logic        st = (kind == 2 || kind == 3);
            logic        mem = ld || st;
            logic        mis = mem && ((addr % acc_size(f3)) != 0);
            int          comp = (!mem || mis) ? 0 : (ld ? dg + dr : dg);
            int          done = 0;
            drive(ld, st, f3, addr, sd, wreg, 2'd3, rw);
            dmem_rdata_i = rdata;
            for (int c = 0; c < 30 && done == 0; c++) begin
                dmem_gnt_i = (c == dg);
                dmem_rvalid_i = ld && (c == dg + dr);
                #2;
                if (mem && !mis && c <= dg) begin
                    chk("rnd req", {dmem_req_o, dmem_we_o}, {1'b1, st});
                    chk("rnd addr", dmem_addr_o, addr & 32'hFFFF_FFFC);
                    if (st) begin
                        chk("rnd be", dmem_be_o, ref_be(f3, addr));
                        chk("rnd wdata", dmem_wdata_o, ref_wdata(f3, sd));
                    end
                end
                if (c == comp) begin
                    chk("rnd valid", {valid_o, stall_o, misaligned_o}, {2'b10, mis});
                    chk("rnd data", data_read_o, ld && !mis ? ref_load(f3, addr, rdata) : 0);
                    chk("rnd reg_write", reg_write_o, rw && !mis);
                    chk("rnd fields", {alu_result_o, write_reg_o, mem_to_reg_o},
                        {addr, wreg, 2'd3});
                    done = 1;
                end else begin
                    chk("rnd busy", {valid_o, stall_o}, 2'b01);
                end
                next_cycle();
                if (done != 0) idle_in();
            end
            dmem_gnt_i = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (done == 0) chk("rnd bound", 0, 1);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- MEM pipeline stage between the EX/MEM pipeline register and memory_writeback_register.
- Turns load/store controls into a req/gnt/rvalid data-memory transaction.
- Aligns store data and byte enables; sign/zero-extends load data.
- Stalls the pipeline while a transaction is outstanding and presents data_read/alu_result/write_reg/mem_to_reg/reg_write to the MEM/WB register.

Parameters:
- GNT_TIMEOUT, 16: max cycles waiting for dmem_gnt_i or dmem_rvalid_i before the access is aborted with bus_error_o.

Ports:
clk_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous active-low reset
valid_i  in  1  instruction present in EX/MEM
alu_result_i  in  32  ALU result / effective address
store_data_i  in  32  rs2 value for stores
write_reg_i  in  5  destination register index
mem_to_reg_i  in  2  writeback mux select
reg_write_i  in  1  register write enable
mem_read_i  in  1  load
mem_write_i  in  1  store
funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
dmem_req_o  out  1  memory request
dmem_we_o  out  1  write request
dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-shifted store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  32  read data word
stall_o  out  1  freeze upstream stages and hold MEM/WB
valid_o  out  1  stage result complete this cycle
data_read_o  out  32  extended load data
alu_result_o  out  32  passthrough ALU result
write_reg_o  out  5  passthrough destination
mem_to_reg_o  out  2  passthrough mux select
reg_write_o  out  1  write enable; forced 0 on fault
misaligned_o  out  1  alignment fault pulse
bus_error_o  out  1  timeout fault pulse

Behaviour:
- Reset (async, reset_ni=0):
  - FSM to IDLE; timeout counter and capture registers cleared.
  - All outputs 0.
  - Any dmem_rvalid_i arriving after reset deassertion with no request outstanding is ignored.
- FSM states: IDLE, WAIT_GNT, WAIT_RDATA.
- IDLE, no memory op (valid_i=1, mem_read_i=mem_write_i=0):
  - valid_o=1 the same cycle; stall_o=0; passthrough fields driven from inputs.
- IDLE, memory op:
  - Alignment is checked first. H/HU/SH fault when addr[0]=1; W/SW fault when addr[1:0]!=0.
  - Misaligned: no request; misaligned_o=1, valid_o=1, reg_write_o=0 for one cycle.
  - Aligned: dmem_req_o=1 combinationally. Address, wdata, be, funct3, write_reg, mem_to_reg, reg_write and alu_result are captured into registers.
  - Store with gnt the same cycle: valid_o=1, stall 0, stay IDLE.
  - Load with gnt the same cycle: go to WAIT_RDATA, stall_o=1.
  - No gnt: go to WAIT_GNT, stall_o=1.
- WAIT_GNT:
  - Drive dmem_req_o/we/addr/be/wdata from captured registers, stable until gnt.
  - On gnt: a store completes (valid_o=1, back to IDLE); a load goes to WAIT_RDATA.
- WAIT_RDATA:
  - dmem_req_o=0, stall_o=1.
  - On dmem_rvalid_i: valid_o=1, data_read_o = extracted and extended lane, passthrough fields from captured registers, stall_o=0, go to IDLE.
  - An rvalid arriving in the same cycle as gnt is not accepted; a load always takes at least 2 cycles.
- Store lanes:
  - B: be=1<<addr[1:0], wdata = byte replicated ×4.
  - H: be=0011 or 1100 by addr[1], wdata = half replicated ×2.
  - W: be=1111.
- Load extraction:
  - B/H: sign-extend from bit 7/15 of the selected lane.
  - BU/HU: zero-extend.
  - W: raw word.
- Timeout:
  - Counter clears on entering WAIT_GNT or WAIT_RDATA and increments each cycle in those states.
  - When it reaches GNT_TIMEOUT: bus_error_o=1, valid_o=1, reg_write_o=0, go to IDLE, stall_o=0.
- Undefined funct3 (011, 110, 111) with a memory op: treated as W.
- mem_read_i and mem_write_i both 1: treated as store.
- valid_i=0 in IDLE: all outputs 0, no request.

Test Plan:
1. ADD passthrough: valid_i=1, alu_result_i=0x1234, write_reg_i=5, reg_write_i=1, no mem op -> same cycle valid_o=1, alu_result_o=0x1234, write_reg_o=5, stall_o=0, dmem_req_o=0.
2. SB, 0-wait: addr=0x103, store_data=0xAB, gnt held 1 -> dmem_addr_o=0x100, be=1000, wdata=0xABABABAB, valid_o=1 same cycle, stall_o=0.
3. LB, waited: addr=0x101, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x0000_80_00 -> stall_o high throughout, data_read_o=0xFFFFFF80 on the rvalid cycle. Repeat as LBU -> data_read_o=0x00000080.
4. LW misaligned at 0x102 -> no dmem_req_o, misaligned_o=1, reg_write_o=0, valid_o=1 for one cycle.
5. Timeout: LW at 0x200, gnt never asserted, GNT_TIMEOUT=16 -> bus_error_o=1 and valid_o=1 exactly 16 cycles after entering WAIT_GNT, then stall_o=0.
6. Reset mid-load: reset_ni=0 in WAIT_RDATA, then release; inject stray rvalid -> all outputs 0 during reset, FSM in IDLE, stray rvalid produces no valid_o.
